// File: rtl/bpred_mem_bank_if.sv
// Bus bundle for the predictor storage bank: instruction memory ports and
// the shared-address HOB / complemented-HOB / LOB weight-table ports.
interface bpred_mem_bank_if #(
    parameter int INSN_AW  = 8,
    parameter int INSN_DW  = 32,
    parameter int TBL_AW   = 6,
    parameter int GHR_SIZE = 12,
    parameter int HOB      = 3,
    parameter int LOB      = 5
) ();
    logic                      insn_wren;
    logic [INSN_AW-1:0]        insn_addr_w;
    logic [INSN_DW-1:0]        insn_data_w;
    logic [INSN_AW-1:0]        insn_addr_r;
    logic [INSN_DW-1:0]        insn_q;

    logic                      tbl_wren;
    logic [TBL_AW-1:0]         tbl_addr_w;
    logic [TBL_AW-1:0]         tbl_addr_r;
    logic [HOB*GHR_SIZE-1:0]   hob_data_w;
    logic [HOB*GHR_SIZE-1:0]   hob_c_data_w;
    logic [LOB*GHR_SIZE-1:0]   lob_data_w;
    logic [HOB*GHR_SIZE-1:0]   hob_q;
    logic [HOB*GHR_SIZE-1:0]   hob_c_q;
    logic [LOB*GHR_SIZE-1:0]   lob_q;

    // Fetch / execute / loader side
    modport master (
        output insn_wren, insn_addr_w, insn_data_w, insn_addr_r,
        output tbl_wren, tbl_addr_w, tbl_addr_r,
        output hob_data_w, hob_c_data_w, lob_data_w,
        input  insn_q, hob_q, hob_c_q, lob_q
    );

    // Storage bank side
    modport slave (
        input  insn_wren, insn_addr_w, insn_data_w, insn_addr_r,
        input  tbl_wren, tbl_addr_w, tbl_addr_r,
        input  hob_data_w, hob_c_data_w, lob_data_w,
        output insn_q, hob_q, hob_c_q, lob_q
    );
endinterface

// File: rtl/bpred_mem_bank.sv
// Storage bank for the perceptron branch predictor front end.
// Four simple dual-port RAMs (instruction, HOB, complemented HOB, LOB) with
// a registered read address. A write that lands on the address being
// captured for read on the same edge yields the old word for one cycle;
// this is done by latching the pre-write word alongside a collision flag.
// Asserting reset forces the read addresses to 0 without touching storage.
module bpred_mem_bank #(
    parameter int INSN_AW  = 8,
    parameter int INSN_DW  = 32,
    parameter int TBL_AW   = 6,
    parameter int GHR_SIZE = 12,
    parameter int HOB      = 3,
    parameter int LOB      = 5
) (
    input  logic             clk,
    input  logic             reset,
    bpred_mem_bank_if.slave  bus
);
    localparam int HW        = HOB * GHR_SIZE;
    localparam int LW        = LOB * GHR_SIZE;
    localparam int INSN_WDS  = 1 << INSN_AW;
    localparam int TBL_WDS   = 1 << TBL_AW;

    // Storage arrays: no reset, zero power-up image.
    logic [INSN_DW-1:0] insn_mem_r  [0:INSN_WDS-1] = '{default: '0};
    logic [HW-1:0]      hob_mem_r   [0:TBL_WDS-1]  = '{default: '0};
    logic [HW-1:0]      hob_c_mem_r [0:TBL_WDS-1]  = '{default: '0};
    logic [LW-1:0]      lob_mem_r   [0:TBL_WDS-1]  = '{default: '0};

    // Read-side state
    logic [INSN_AW-1:0] insn_raddr_r;
    logic               insn_coll_r;
    logic [INSN_DW-1:0] insn_old_r;
    logic [TBL_AW-1:0]  tbl_raddr_r;
    logic               tbl_coll_r;
    logic [HW-1:0]      hob_old_r;
    logic [HW-1:0]      hob_c_old_r;
    logic [LW-1:0]      lob_old_r;

    // Same-edge write/read address match on each port
    logic               insn_hit_s;
    logic               tbl_hit_s;

    assign insn_hit_s = bus.insn_wren && (bus.insn_addr_w == bus.insn_addr_r);
    assign tbl_hit_s  = bus.tbl_wren  && (bus.tbl_addr_w  == bus.tbl_addr_r);

    // Instruction memory write port (honoured regardless of reset)
    always_ff @(posedge clk) begin
        if (bus.insn_wren) begin
            insn_mem_r[bus.insn_addr_w] <= bus.insn_data_w;
        end
    end

    // Weight-table write port: all three tables share address and enable
    always_ff @(posedge clk) begin
        if (bus.tbl_wren) begin
            hob_mem_r[bus.tbl_addr_w]   <= bus.hob_data_w;
            hob_c_mem_r[bus.tbl_addr_w] <= bus.hob_c_data_w;
            lob_mem_r[bus.tbl_addr_w]   <= bus.lob_data_w;
        end
    end

    // Instruction read address register with old-data capture on collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insn_raddr_r <= {INSN_AW{1'b0}};
            insn_coll_r  <= 1'b0;
            insn_old_r   <= {INSN_DW{1'b0}};
        end else begin
            insn_raddr_r <= bus.insn_addr_r;
            insn_coll_r  <= insn_hit_s;
            insn_old_r   <= insn_mem_r[bus.insn_addr_r];
        end
    end

    // Weight-table read address register with old-data capture on collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_raddr_r <= {TBL_AW{1'b0}};
            tbl_coll_r  <= 1'b0;
            hob_old_r   <= {HW{1'b0}};
            hob_c_old_r <= {HW{1'b0}};
            lob_old_r   <= {LW{1'b0}};
        end else begin
            tbl_raddr_r <= bus.tbl_addr_r;
            tbl_coll_r  <= tbl_hit_s;
            hob_old_r   <= hob_mem_r[bus.tbl_addr_r];
            hob_c_old_r <= hob_c_mem_r[bus.tbl_addr_r];
            lob_old_r   <= lob_mem_r[bus.tbl_addr_r];
        end
    end

    // Instruction read data: pre-write word for one cycle after a collision
    always_comb begin
        if (insn_coll_r) begin
            bus.insn_q = insn_old_r;
        end else begin
            bus.insn_q = insn_mem_r[insn_raddr_r];
        end
    end

    // Weight-table read data: pre-write words for one cycle after a collision
    always_comb begin
        if (tbl_coll_r) begin
            bus.hob_q   = hob_old_r;
            bus.hob_c_q = hob_c_old_r;
            bus.lob_q   = lob_old_r;
        end else begin
            bus.hob_q   = hob_mem_r[tbl_raddr_r];
            bus.hob_c_q = hob_c_mem_r[tbl_raddr_r];
            bus.lob_q   = lob_mem_r[tbl_raddr_r];
        end
    end

endmodule

// File: tb/tb_bpred_mem_bank.sv
// Self-checking bench for bpred_mem_bank: table of vectors applied one per
// clock, expected outputs queued at drive time and compared after the edge,
// followed by hand-written async-reset and reset-sweep sequences.
module tb_bpred_mem_bank;
    logic clk;
    logic reset;

    bpred_mem_bank_if bus ();

    bpred_mem_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        iw;
        logic [7:0]  iaw;
        logic [31:0] idw;
        logic [7:0]  iar;
        logic        tw;
        logic [5:0]  taw;
        logic [5:0]  tar;
        logic [35:0] hob;
        logic [35:0] hobc;
        logic [59:0] lob;
        logic [31:0] e_insn;
        logic [35:0] e_hob;
        logic [35:0] e_hobc;
        logic [59:0] e_lob;
    } vec_t;

    typedef struct {
        logic [31:0] insn;
        logic [35:0] hob;
        logic [35:0] hobc;
        logic [59:0] lob;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [17];

    localparam logic [35:0] H63 = 36'h123456789;
    localparam logic [35:0] C63 = 36'hEDCBA9877;
    localparam logic [59:0] L63 = 60'hFEDCBA987654321;
    localparam logic [35:0] XH  = 36'h111111111;
    localparam logic [35:0] XC  = 36'h222222222;
    localparam logic [59:0] XL  = 60'h333333333333333;
    localparam logic [35:0] YH  = 36'h444444444;
    localparam logic [35:0] YC  = 36'h555555555;
    localparam logic [59:0] YL  = 60'h666666666666666;
    localparam logic [35:0] H0  = 36'h0000005A5;
    localparam logic [35:0] C0  = 36'h000000A5A;
    localparam logic [59:0] L0  = 60'h000000000000777;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic iw, input logic [7:0] iaw, input logic [31:0] idw,
        input logic [7:0] iar, input logic tw, input logic [5:0] taw,
        input logic [5:0] tar, input logic [35:0] hob, input logic [35:0] hobc,
        input logic [59:0] lob, input logic [31:0] e_insn,
        input logic [35:0] e_hob, input logic [35:0] e_hobc,
        input logic [59:0] e_lob);
        vec_t v;
        v.iw = iw; v.iaw = iaw; v.idw = idw; v.iar = iar;
        v.tw = tw; v.taw = taw; v.tar = tar;
        v.hob = hob; v.hobc = hobc; v.lob = lob;
        v.e_insn = e_insn; v.e_hob = e_hob; v.e_hobc = e_hobc; v.e_lob = e_lob;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [31:0] ei, input logic [35:0] eh,
                           input logic [35:0] ec, input logic [59:0] el);
        chk({nm, ".insn_q"},  {32'd0, bus.insn_q},  {32'd0, ei});
        chk({nm, ".hob_q"},   {28'd0, bus.hob_q},   {28'd0, eh});
        chk({nm, ".hob_c_q"}, {28'd0, bus.hob_c_q}, {28'd0, ec});
        chk({nm, ".lob_q"},   {4'd0, bus.lob_q},    {4'd0, el});
    endtask

    // Drive one vector, queue its expectation, clock, then compare.
    task automatic apply(input vec_t v, input string nm);
        exp_t e;
        bus.insn_wren    = v.iw;
        bus.insn_addr_w  = v.iaw;
        bus.insn_data_w  = v.idw;
        bus.insn_addr_r  = v.iar;
        bus.tbl_wren     = v.tw;
        bus.tbl_addr_w   = v.taw;
        bus.tbl_addr_r   = v.tar;
        bus.hob_data_w   = v.hob;
        bus.hob_c_data_w = v.hobc;
        bus.lob_data_w   = v.lob;
        e.insn = v.e_insn; e.hob = v.e_hob; e.hobc = v.e_hobc; e.lob = v.e_lob;
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard empty actual=0 expected=1", nm);
        end else begin
            e = exp_q.pop_front();
            chk_all(e.name, e.insn, e.hob, e.hobc, e.lob);
        end
    endtask

    initial begin
        //  iw iaw   idw            iar  tw taw  tar  hob   hobc  lob   e_insn         e_hob  e_hobc e_lob
        vecs[0]  = mk(1'b1, 8'd5, 32'hDEADBEEF, 8'd5, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0, 32'd0, 36'd0, 36'd0, 60'd0);
        vecs[1]  = mk(1'b0, 8'd0, 32'd0, 8'd5, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0, 32'hDEADBEEF, 36'd0, 36'd0, 60'd0);
        vecs[2]  = mk(1'b0, 8'd0, 32'd0, 8'd6, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0, 32'd0, 36'd0, 36'd0, 60'd0);
        vecs[3]  = mk(1'b0, 8'd0, 32'd0, 8'd6, 1'b1, 6'd63, 6'd0, H63, C63, L63, 32'd0, 36'd0, 36'd0, 60'd0);
        vecs[4]  = mk(1'b0, 8'd0, 32'd0, 8'd6, 1'b0, 6'd0, 6'd63, 36'd0, 36'd0, 60'd0, 32'd0, H63, C63, L63);
        vecs[5]  = mk(1'b0, 8'd0, 32'd0, 8'd6, 1'b0, 6'd0, 6'd0, 36'd0, 36'd0, 60'd0, 32'd0, 36'd0, 36'd0, 60'd0);
        vecs[6]  = mk(1'b0, 8'd0, 32'd0, 8'd6, 1'b1, 6'd10, 6'd0, 36'd1, 36'd0, 60'd0, 32'd0, 36'd0, 36'd0, 60'd0);
        vecs[7]  = mk(1'b0, 8'd0, 32'd0, 8'd6, 1'b1, 6'd10, 6'd10, 36'd2, 36'd0, 60'd0, 32'd0, 36'd1, 36'd0, 60'd0);
        vecs[8]  = mk(1'b0, 8'd0, 32'd0, 8'd6, 1'b0, 6'd0, 6'd10, 36'd0, 36'd0, 60'd0, 32'd0, 36'd2, 36'd0, 60'd0);
        vecs[9]  = mk(1'b1, 8'd1, 32'hA5A5A5A5, 8'd1, 1'b1, 6'd1, 6'd1, 36'h0AB, 36'hF54, 60'h123, 32'd0, 36'd0, 36'd0, 60'd0);
        vecs[10] = mk(1'b0, 8'd0, 32'd0, 8'd1, 1'b0, 6'd0, 6'd1, 36'd0, 36'd0, 60'd0, 32'hA5A5A5A5, 36'h0AB, 36'hF54, 60'h123);
        vecs[11] = mk(1'b1, 8'd7, 32'h01234567, 8'd5, 1'b1, 6'd2, 6'd63, XH, XC, XL, 32'hDEADBEEF, H63, C63, L63);
        vecs[12] = mk(1'b0, 8'd0, 32'd0, 8'd7, 1'b0, 6'd0, 6'd2, 36'd0, 36'd0, 60'd0, 32'h01234567, XH, XC, XL);
        vecs[13] = mk(1'b0, 8'd0, 32'd0, 8'd7, 1'b0, 6'd0, 6'd2, 36'd0, 36'd0, 60'd0, 32'h01234567, XH, XC, XL);
        vecs[14] = mk(1'b1, 8'd7, 32'h89ABCDEF, 8'd7, 1'b1, 6'd2, 6'd2, YH, YC, YL, 32'h01234567, XH, XC, XL);
        vecs[15] = mk(1'b0, 8'd0, 32'd0, 8'd7, 1'b0, 6'd0, 6'd2, 36'd0, 36'd0, 60'd0, 32'h89ABCDEF, YH, YC, YL);
        vecs[16] = mk(1'b0, 8'd0, 32'd0, 8'd7, 1'b1, 6'd0, 6'd2, H0, C0, L0, 32'h89ABCDEF, YH, YC, YL);

        reset = 1'b1;
        bus.insn_wren = 1'b0; bus.insn_addr_w = 8'd0; bus.insn_data_w = 32'd0;
        bus.insn_addr_r = 8'd0; bus.tbl_wren = 1'b0; bus.tbl_addr_w = 6'd0;
        bus.tbl_addr_r = 6'd0; bus.hob_data_w = 36'd0; bus.hob_c_data_w = 36'd0;
        bus.lob_data_w = 60'd0;
        #7;
        chk_all("reset_state", 32'd0, 36'd0, 36'd0, 60'd0);
        #2;
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset between edges while reading a nonzero entry
        apply(mk(1'b0, 8'd0, 32'd0, 8'd5, 1'b0, 6'd0, 6'd63, 36'd0, 36'd0, 60'd0,
                 32'hDEADBEEF, H63, C63, L63), "pre_async");
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset_now", 32'd0, H0, C0, L0);
        apply(mk(1'b0, 8'd0, 32'd0, 8'd5, 1'b0, 6'd0, 6'd63, 36'd0, 36'd0, 60'd0,
                 32'd0, H0, C0, L0), "reset_hold");
        reset = 1'b0;
        apply(mk(1'b0, 8'd0, 32'd0, 8'd5, 1'b0, 6'd0, 6'd63, 36'd0, 36'd0, 60'd0,
                 32'hDEADBEEF, H63, C63, L63), "post_async");

        // Sweep-clear every table entry while reset is held
        reset = 1'b1;
        for (int a = 0; a < 64; a++) begin
            apply(mk(1'b0, 8'd0, 32'd0, 8'd5, 1'b1, 6'(a), 6'd63, 36'd0, 36'd0, 60'd0,
                     32'd0, 36'd0, 36'd0, 60'd0), $sformatf("sweep%0d", a));
        end
        reset = 1'b0;
        apply(mk(1'b0, 8'd0, 32'd0, 8'd5, 1'b0, 6'd0, 6'd63, 36'd0, 36'd0, 60'd0,
                 32'hDEADBEEF, 36'd0, 36'd0, 60'd0), "after_sweep63");
        apply(mk(1'b0, 8'd0, 32'd0, 8'd1, 1'b0, 6'd0, 6'd1, 36'd0, 36'd0, 60'd0,
                 32'hA5A5A5A5, 36'd0, 36'd0, 60'd0), "after_sweep1");
        apply(mk(1'b0, 8'd0, 32'd0, 8'd7, 1'b0, 6'd0, 6'd2, 36'd0, 36'd0, 60'd0,
                 32'h89ABCDEF, 36'd0, 36'd0, 60'd0), "after_sweep2");
        apply(mk(1'b0, 8'd0, 32'd0, 8'd0, 1'b0, 6'd0, 6'd10, 36'd0, 36'd0, 60'd0,
                 32'd0, 36'd0, 36'd0, 60'd0), "after_sweep10");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
